// File: rtl/rvx_pkg.sv
// Shared RVX10P types: result-select encoding, register address type and datapath width.
package rvx_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // True when an architectural address maps onto a physical entry of an nregs-deep file.
    function automatic logic addr_in_range(input reg_addr_t addr, input int nregs);
        return (32'(addr) < nregs);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register array: one synchronous write port, two async read ports and a raw debug port.
// x0 and out-of-range addresses read as zero and are never written.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] dbg_data_o
);
    import rvx_pkg::*;

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] rf_q [NREGS];

    function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != '0 && addr_in_range(addr, NREGS)) begin
            val = rf_q[addr[AW-1:0]];
        end
        return val;
    endfunction

    // Reset clears every entry so nothing undefined leaks out after the first reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0 && addr_in_range(waddr_i, NREGS)) begin
            rf_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o   = read_port(raddr1_i);
        rdata2_o   = read_port(raddr2_i);
        dbg_data_o = read_port(dbg_addr_i);
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register-file write with same-cycle bypass to decode,
// and the retired-instruction counter.
module wb_regfile #(
    parameter int XLEN  = rvx_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic             ValidW,
    input  logic [4:0]       RdW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [XLEN-1:0]  ResultW,
    input  logic [4:0]       DbgAddr,
    output logic [XLEN-1:0]  DbgData,
    output logic [CNT_W-1:0] InstretW
);
    import rvx_pkg::*;

    logic [XLEN-1:0]  result_d;
    logic [XLEN-1:0]  arr_rd1;
    logic [XLEN-1:0]  arr_rd2;
    logic             byp1;
    logic             byp2;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    // Encoding 11 is reserved and falls back to the ALU result.
    always_comb begin
        result_d = ALUResultW;
        case (result_src_e'(ResultSrcW))
            RES_MEM: result_d = ReadDataW;
            RES_PC4: result_d = PCPlus4W;
            default: result_d = ALUResultW;
        endcase
    end

    assign ResultW = result_d;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk        (clk),
        .reset      (reset),
        .we_i       (RegWriteW),
        .waddr_i    (RdW),
        .wdata_i    (result_d),
        .raddr1_i   (Rs1D),
        .rdata1_o   (arr_rd1),
        .raddr2_i   (Rs2D),
        .rdata2_o   (arr_rd2),
        .dbg_addr_i (DbgAddr),
        .dbg_data_o (DbgData)
    );

    // Bypass deliberately ignores ValidW and reset: bubbles arrive with RegWriteW low.
    always_comb begin
        byp1 = RegWriteW && (RdW == Rs1D) && (Rs1D != '0);
        byp2 = RegWriteW && (RdW == Rs2D) && (Rs2D != '0);
        RD1D = byp1 ? result_d : arr_rd1;
        RD2D = byp2 ? result_d : arr_rd2;
    end

    always_comb begin
        instret_d = instret_q;
        if (ValidW) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign InstretW = instret_q;

endmodule
